// File: rtl/gpu_axi_target.sv
// AXI4-lite register file for GPU frame control: programs the triangle sequencer and reports completion.
// Define GPU_AXI_TARGET_IRQ_EN to add the IRQ_ENABLE register and a live irq output.
module gpu_axi_target #(
  parameter int SADDR_WIDTH = 32,
  parameter int MADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [SADDR_WIDTH-1:0] awaddr,
  input  logic [2:0]             awprot,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [31:0]            wdata,
  input  logic [3:0]             wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic [SADDR_WIDTH-1:0] araddr,
  input  logic [2:0]             arprot,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [31:0]            rdata,
  output logic [1:0]             rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic                   frame_start,
  input  logic                   frame_end,
  output logic [31:0]            triangles_count,
  output logic [MADDR_WIDTH-1:0] base_addr_vertex,
  output logic [MADDR_WIDTH-1:0] base_addr_color,
  output logic                   irq
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                   aw_held, w_held;
  logic [SADDR_WIDTH-1:0] aw_addr_q;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;
  logic                   busy, done, err, irq_en;
  logic [31:0]            frame_count;

  logic                   aw_hs, w_hs, ar_hs, commit;
  logic [SADDR_WIDTH-1:0] wr_addr;
  logic [31:0]            wr_data;
  logic [3:0]             wr_strb;
  logic [2:0]             wr_idx, rd_idx;
  logic                   wr_bad, rd_bad;
  logic                   busy_n, done_n, err_n, irq_en_n, fs_n;
  logic [31:0]            tri_n, fc_n, rd_val;
  logic [MADDR_WIDTH-1:0] vb_n, cb_n;
  logic [1:0]             bresp_n;
  logic                   unused_ok;

  assign awready = !aw_held && !bvalid;
  assign wready  = !w_held && !bvalid;
  assign arready = !rvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  // A write commits once both halves are available, either from the holding registers or this cycle.
  assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr = aw_held ? aw_addr_q : awaddr;
  assign wr_data = w_held ? w_data_q : wdata;
  assign wr_strb = w_held ? w_strb_q : wstrb;
  assign wr_idx  = wr_addr[4:2];
  assign rd_idx  = araddr[4:2];
  assign wr_bad  = ((wr_addr >> 5) != '0) || (wr_idx == 3'd7);
  assign rd_bad  = ((araddr >> 5) != '0) || (rd_idx == 3'd7);

  assign unused_ok = ^{awprot, arprot, wr_addr[1:0], araddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

  always_comb begin
    busy_n   = busy;
    done_n   = done;
    err_n    = err;
    irq_en_n = irq_en;
    tri_n    = triangles_count;
    vb_n     = base_addr_vertex;
    cb_n     = base_addr_color;
    fc_n     = frame_count;
    fs_n     = 1'b0;
    bresp_n  = RESP_OKAY;
    if (commit) begin
      if (wr_bad) bresp_n = RESP_SLVERR;
      else begin
        case (wr_idx)
          3'd0: if (wr_strb[0] && wr_data[0]) begin
            if (busy) err_n = 1'b1;
            else if (triangles_count != '0) begin
              busy_n = 1'b1;
              fs_n   = 1'b1;
            end else done_n = 1'b1;
          end
          3'd1: if (wr_strb[0]) begin
            if (wr_data[1]) done_n = 1'b0;
            if (wr_data[2]) err_n = 1'b0;
          end
          3'd2: if (busy) bresp_n = RESP_SLVERR;
                else tri_n = merge(triangles_count, wr_data, wr_strb);
          3'd3: if (busy) bresp_n = RESP_SLVERR;
                else vb_n = MADDR_WIDTH'(merge(32'(base_addr_vertex), wr_data, wr_strb));
          3'd4: if (busy) bresp_n = RESP_SLVERR;
                else cb_n = MADDR_WIDTH'(merge(32'(base_addr_color), wr_data, wr_strb));
          3'd5: begin
`ifdef GPU_AXI_TARGET_IRQ_EN
            if (wr_strb[0]) irq_en_n = wr_data[0];
`endif
          end
          default: ;
        endcase
      end
    end
    // Sequencer completion comes last so a same-cycle W1C of DONE loses to the hardware set.
    if (frame_end && busy) begin
      busy_n = 1'b0;
      done_n = 1'b1;
      fc_n   = frame_count + 32'd1;
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      3'd1:    rd_val = {29'b0, err, done, busy};
      3'd2:    rd_val = triangles_count;
      3'd3:    rd_val = 32'(base_addr_vertex);
      3'd4:    rd_val = 32'(base_addr_color);
      3'd5:    rd_val = {31'b0, irq_en};
      3'd6:    rd_val = frame_count;
      default: rd_val = '0;
    endcase
    if (rd_bad) rd_val = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_held <= 1'b0;  w_held <= 1'b0;
      aw_addr_q <= '0;  w_data_q <= '0;  w_strb_q <= '0;
      bvalid <= 1'b0;   bresp <= RESP_OKAY;
      rvalid <= 1'b0;   rresp <= RESP_OKAY;  rdata <= '0;
      busy <= 1'b0;     done <= 1'b0;  err <= 1'b0;  irq_en <= 1'b0;
      triangles_count <= '0;  base_addr_vertex <= '0;  base_addr_color <= '0;
      frame_count <= '0;  frame_start <= 1'b0;  irq <= 1'b0;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= bresp_n;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
        if (bready) bvalid <= 1'b0;
      end
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata  <= rd_val;
        rresp  <= rd_bad ? RESP_SLVERR : RESP_OKAY;
      end else if (rready) rvalid <= 1'b0;
      busy            <= busy_n;
      done            <= done_n;
      err             <= err_n;
      irq_en          <= irq_en_n;
      triangles_count <= tri_n;
      base_addr_vertex <= vb_n;
      base_addr_color <= cb_n;
      frame_count     <= fc_n;
      frame_start     <= fs_n;
      irq             <= done_n & irq_en_n;
    end
  end
endmodule
